// File: rtl/sequenciador_ula.sv
// sequenciador_ula: operand-entry sequencer placed directly upstream of the 8-bit ULA.
// The user enters opcode, A, B and carry from the board switches, one field per confirm
// press. The registered operands drive the combinational ULA. The ULA result and flags
// are then captured into display registers.
//
// Ports:
//   Clock_in       system clock, rising edge
//   Reset_in       asynchronous active-high reset
//   Dados_in       switch value, sampled on a confirm edge
//   Carry_in       carry/borrow switch, sampled with the last operand
//   Confirma_in    confirm button (debounced, synchronised, level)
//   Cancela_in     cancel button (debounced, synchronised, level)
//   Saida_ula_in   ULA result
//   Flags_ula_in   ULA flags {overflow, carry, zero}
//   A_out, B_out, C_out, Operacao_out   registered operands to the ULA
//   Resultado_out, Flags_out            captured result and flags
//   Estado_out     current state encoding
//   Valido_out     high while the result is shown
//   Erro_out       one-cycle pulse on a rejected opcode
//
// Optional feature: define SEQ_ULA_ACUMULADOR_EN to enable result chaining.
// With the macro defined, a confirm while the result is shown loads the result into A.
// Later operations then skip A entry until reset or cancel.

module sequenciador_ula (
   input  logic       Clock_in,
   input  logic       Reset_in,
   input  logic [7:0] Dados_in,
   input  logic       Carry_in,
   input  logic       Confirma_in,
   input  logic       Cancela_in,
   input  logic [7:0] Saida_ula_in,
   input  logic [2:0] Flags_ula_in,
   output logic [7:0] A_out,
   output logic [7:0] B_out,
   output logic       C_out,
   output logic [2:0] Operacao_out,
   output logic [7:0] Resultado_out,
   output logic [2:0] Flags_out,
   output logic [2:0] Estado_out,
   output logic       Valido_out,
   output logic       Erro_out
);

   typedef enum logic [2:0] {
      StCarregaOp = 3'd0,
      StCarregaA  = 3'd1,
      StCarregaB  = 3'd2,
      StExecuta   = 3'd3,
      StExibe     = 3'd4
   } estado_t;

   localparam logic [2:0] OpNot    = 3'b011;
   localparam logic [2:0] OpMaxVal = 3'b101;

   estado_t    estado_q;
   logic [7:0] a_q, b_q, resultado_q;
   logic       c_q, valido_q, erro_q;
   logic [2:0] op_q, flags_q;
   logic       conf_prev_q;
   logic       conf;
`ifdef SEQ_ULA_ACUMULADOR_EN
   logic       acc_q;
`endif

   // conf_prev resets to 1, so a button held through reset release produces no edge.
   assign conf = Confirma_in & ~conf_prev_q;

   always_ff @(posedge Clock_in or posedge Reset_in) begin
      if (Reset_in) begin
         estado_q    <= StCarregaOp;
         a_q         <= 8'h00;
         b_q         <= 8'h00;
         c_q         <= 1'b0;
         op_q        <= 3'b000;
         resultado_q <= 8'h00;
         flags_q     <= 3'b000;
         valido_q    <= 1'b0;
         erro_q      <= 1'b0;
         conf_prev_q <= 1'b1;
`ifdef SEQ_ULA_ACUMULADOR_EN
         acc_q       <= 1'b0;
`endif
      end else begin
         conf_prev_q <= Confirma_in;
         erro_q      <= 1'b0;
         // Cancel wins over confirm. It is ignored in EXECUTA so the capture always completes.
         if (Cancela_in && (estado_q != StExecuta)) begin
            estado_q <= StCarregaOp;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            c_q      <= 1'b0;
            op_q     <= 3'b000;
            valido_q <= 1'b0;
`ifdef SEQ_ULA_ACUMULADOR_EN
            acc_q    <= 1'b0;
`endif
         end else begin
            case (estado_q)
               StCarregaOp: begin
                  if (conf) begin
                     if (Dados_in[2:0] > OpMaxVal) begin
                        erro_q <= 1'b1;
                     end else begin
                        op_q <= Dados_in[2:0];
`ifdef SEQ_ULA_ACUMULADOR_EN
                        if (acc_q) begin
                           // A already holds the previous result.
                           if (Dados_in[2:0] == OpNot) begin
                              c_q      <= Carry_in;
                              estado_q <= StExecuta;
                           end else begin
                              estado_q <= StCarregaB;
                           end
                        end else begin
                           estado_q <= StCarregaA;
                        end
`else
                        estado_q <= StCarregaA;
`endif
                     end
                  end
               end
               StCarregaA: begin
                  if (conf) begin
                     a_q <= Dados_in;
                     // NOT is unary: take the carry here and skip B entry.
                     if (op_q == OpNot) begin
                        c_q      <= Carry_in;
                        estado_q <= StExecuta;
                     end else begin
                        estado_q <= StCarregaB;
                     end
                  end
               end
               StCarregaB: begin
                  if (conf) begin
                     b_q      <= Dados_in;
                     c_q      <= Carry_in;
                     estado_q <= StExecuta;
                  end
               end
               StExecuta: begin
                  resultado_q <= Saida_ula_in;
                  flags_q     <= Flags_ula_in;
                  valido_q    <= 1'b1;
                  estado_q    <= StExibe;
               end
               StExibe: begin
                  if (conf) begin
                     valido_q <= 1'b0;
                     estado_q <= StCarregaOp;
`ifdef SEQ_ULA_ACUMULADOR_EN
                     a_q      <= resultado_q;
                     acc_q    <= 1'b1;
`endif
                  end
               end
               default: begin
                  // Unreachable encodings fall back to opcode entry.
                  valido_q <= 1'b0;
                  estado_q <= StCarregaOp;
               end
            endcase
         end
      end
   end

   assign A_out         = a_q;
   assign B_out         = b_q;
   assign C_out         = c_q;
   assign Operacao_out  = op_q;
   assign Resultado_out = resultado_q;
   assign Flags_out     = flags_q;
   assign Estado_out    = estado_q;
   assign Valido_out    = valido_q;
   assign Erro_out      = erro_q;

endmodule

// File: tb/tb_sequenciador_ula.sv
// Directed bench for sequenciador_ula. A small ULA model (ADD/NOT/AND) sits in the loop.
module tb_sequenciador_ula;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] dados;
   logic       carry;
   logic       confirma;
   logic       cancela;
   logic [7:0] saida_ula;
   logic [2:0] flags_ula;
   logic [7:0] a, b, resultado;
   logic       c, valido, erro;
   logic [2:0] op, flags, estado;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sequenciador_ula dut (
      .Clock_in      (clk),
      .Reset_in      (rst),
      .Dados_in      (dados),
      .Carry_in      (carry),
      .Confirma_in   (confirma),
      .Cancela_in    (cancela),
      .Saida_ula_in  (saida_ula),
      .Flags_ula_in  (flags_ula),
      .A_out         (a),
      .B_out         (b),
      .C_out         (c),
      .Operacao_out  (op),
      .Resultado_out (resultado),
      .Flags_out     (flags),
      .Estado_out    (estado),
      .Valido_out    (valido),
      .Erro_out      (erro)
   );

   // ULA model: 100 ADD with carry, 011 NOT, anything else AND.
   logic [8:0] soma;
   always_comb begin
      soma      = {1'b0, a} + {1'b0, b} + {8'h00, c};
      saida_ula = a & b;
      flags_ula = 3'b000;
      case (op)
         3'b100: begin
            saida_ula    = soma[7:0];
            flags_ula[1] = soma[8];
            flags_ula[2] = (a[7] == b[7]) && (soma[7] != a[7]);
         end
         3'b011: saida_ula = ~a;
         default: saida_ula = a & b;
      endcase
      flags_ula[0] = (saida_ula == 8'h00);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic press(input logic [7:0] d, input logic cy);
      @(negedge clk);
      dados    = d;
      carry    = cy;
      confirma = 1'b1;
      @(negedge clk);
      confirma = 1'b0;
   endtask

   task automatic cancel_pulse();
      @(negedge clk);
      cancela = 1'b1;
      @(negedge clk);
      cancela = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      dados    = 8'h04;
      carry    = 1'b0;
      confirma = 1'b1;
      cancela  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_estado", estado, 3'd0);
      check("rst_a", a, 8'h00);
      check("rst_res", resultado, 8'h00);
      check("rst_valido", valido, 1'b0);
      check("rst_erro", erro, 1'b0);

      // Button held through reset release: no action.
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("held_rst_estado", estado, 3'd0);
      confirma = 1'b0;

      // Held button: one action only.
      @(negedge clk);
      confirma = 1'b1;
      repeat (3) @(negedge clk);
      check("held_estado", estado, 3'd1);
      check("held_op", op, 3'b100);
      check("held_a", a, 8'h00);
      confirma = 1'b0;
      cancel_pulse();
      check("cancel_op", op, 3'b000);

      // Invalid opcode.
      press(8'h06, 1'b0);
      check("inv_erro", erro, 1'b1);
      check("inv_estado", estado, 3'd0);
      check("inv_op", op, 3'b000);
      @(negedge clk);
      check("inv_erro_pulse", erro, 1'b0);

      // ADD 0x3C + 0x0F.
      press(8'h04, 1'b0);
      press(8'h3C, 1'b0);
      check("add_estado_b", estado, 3'd2);
      press(8'h0F, 1'b0);
      check("add_estado_ex", estado, 3'd3);
      check("add_valido_early", valido, 1'b0);
      @(negedge clk);
      check("add_res", resultado, 8'h4B);
      check("add_flags", flags, 3'b000);
      check("add_valido", valido, 1'b1);
      check("add_estado_exibe", estado, 3'd4);
      cancel_pulse();
      check("add_cancel_res", resultado, 8'h4B);

      // ADD wrap 0xFF + 0x01.
      press(8'h04, 1'b0);
      press(8'hFF, 1'b0);
      press(8'h01, 1'b0);
      @(negedge clk);
      check("wrap_res", resultado, 8'h00);
      check("wrap_flags", flags, 3'b011);
      cancel_pulse();

      // NOT 0xA5 skips B entry.
      press(8'h03, 1'b0);
      press(8'hA5, 1'b1);
      check("not_estado", estado, 3'd3);
      check("not_c", c, 1'b1);
      @(negedge clk);
      check("not_res", resultado, 8'h5A);
      check("not_flags", flags, 3'b000);
      cancel_pulse();

      // Cancel and confirm together in CARREGA_B.
      press(8'h04, 1'b0);
      press(8'h77, 1'b0);
      check("cc_estado_b", estado, 3'd2);
      @(negedge clk);
      dados    = 8'h33;
      confirma = 1'b1;
      cancela  = 1'b1;
      @(negedge clk);
      confirma = 1'b0;
      cancela  = 1'b0;
      check("cc_estado", estado, 3'd0);
      check("cc_a", a, 8'h00);
      check("cc_b", b, 8'h00);
      check("cc_op", op, 3'b000);
      check("cc_res", resultado, 8'h5A);

      // Reset during EXECUTA.
      press(8'h04, 1'b0);
      press(8'h01, 1'b0);
      press(8'h02, 1'b1);
      check("rx_estado_ex", estado, 3'd3);
      rst = 1'b1;
      #1;
      check("rx_estado", estado, 3'd0);
      check("rx_a", a, 8'h00);
      check("rx_b", b, 8'h00);
      check("rx_c", c, 1'b0);
      check("rx_op", op, 3'b000);
      check("rx_res", resultado, 8'h00);
      @(negedge clk);
      check("rx_no_capture", resultado, 8'h00);
      check("rx_flags", flags, 3'b000);
      check("rx_valido", valido, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Chaining: 0x10 + 0x01, confirm in EXIBE, then ADD again.
      press(8'h04, 1'b0);
      press(8'h10, 1'b0);
      press(8'h01, 1'b0);
      @(negedge clk);
      check("ch_res1", resultado, 8'h11);
      press(8'h00, 1'b0);
      check("ch_estado_op", estado, 3'd0);
      check("ch_valido", valido, 1'b0);
`ifdef SEQ_ULA_ACUMULADOR_EN
      check("ch_a_acc", a, 8'h11);
      press(8'h04, 1'b0);
      check("ch_skip_a", estado, 3'd2);
      press(8'h02, 1'b0);
      @(negedge clk);
      check("ch_res2", resultado, 8'h13);
`else
      check("ch_a_keep", a, 8'h10);
      press(8'h04, 1'b0);
      check("ch_full_seq", estado, 3'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
